fetch_pc_predictor: RTL and testbench
=====================================

// Module: fetch_pc_predictor
// PURPOSE
//  Fetch-stage next-PC generator that sits directly upstream of and around the branch target buffer.
//  Drives the BTB lookup PC and consumes its registered target, where 0 means no prediction.
//  Tracks every fetched instruction's predicted next-PC until it resolves in EX.
//  On a mispredict it flushes and redirects fetch; on every resolved branch it produces the BTB update.
// PARAMETERS
//  RESET_PC     64'h0  fetch address of the first instruction after reset
//  PIPE_DEPTH   2      cycles from fetch to EX resolution; tracking-slot count, >=1
//  INSTR_BYTES  4      sequential PC increment
// PORTS
//  clk                  in   1   clock; all state updates on posedge
//  arst_n               in   1   asynchronous, active-low reset
//  en                   in   1   pipeline advance; 0 = stall (PC and tracking hold)
//  predicted_branch_pc  in   64  BTB output for fetch_pc this cycle; 0 = none
//  current_pc           out  64  BTB lookup address = next-PC mux output (combinational)
//  fetch_pc             out  64  PC of instruction fetched this cycle (registered)
//  fetch_valid          out  1   fetch_pc is a real, non-squashed fetch
//  ex_valid             in   1   EX holds the oldest tracked instruction this cycle
//  ex_is_branch         in   1   that instruction is a branch/jump
//  ex_taken             in   1   resolved direction
//  ex_target            in   64  resolved target (ignored unless ex_taken)
//  flush                out  1   squash all younger in-flight instructions (registered pulse)
//  btb_prev_pc          out  64  PC of the resolved branch (to BTB prev_pc)
//  btb_branch_pc        out  64  resolved target (to BTB branch_pc)
//  btb_was_taken        out  1   BTB write strobe, one cycle
//  mispredict_count     out  32  saturating mispredict counter
// BEHAVIOUR
//  Reset: state=BOOT, fetch_pc=RESET_PC, fetch_valid=0, flush=0, btb_*=0, count=0, all slots invalid.
//  FSM
//   BOOT: current_pc=RESET_PC; next state RUN, fetch_valid=1.
//   RUN:  next-PC mux -> current_pc. Priority:
//         (1) mispredict -> actual_next;
//         (2) en=0 -> fetch_pc;
//         (3) predicted_branch_pc!=0 -> predicted_branch_pc;
//         (4) fetch_pc+INSTR_BYTES.
//         Mispredict -> FLUSH.
//   FLUSH: flush=1 for exactly one cycle, fetch_valid=0, slots invalid.
//          fetch_pc already holds the redirect target; RUN next.
//  Tracking: PIPE_DEPTH-entry shift register {valid, pc, pred_next}.
//   - On en=1 in RUN: push {fetch_valid, fetch_pc, chosen next-PC}; oldest slot shifts out.
//   - ex_* inputs always refer to the oldest slot.
//   - ex_valid with an invalid oldest slot is ignored.
//  Resolution (ex_valid & oldest.valid):
//   - actual_next = (ex_is_branch & ex_taken) ? ex_target : oldest.pc+INSTR_BYTES.
//   - mispredict  = actual_next != oldest.pred_next.
//   - Resolved even when en=0; redirect overrides stall.
//  BTB update, registered, 1-cycle latency:
//   - btb_was_taken=1 iff resolved & ex_is_branch & ex_taken.
//   - btb_prev_pc=oldest.pc, btb_branch_pc=ex_target.
//   - Not-taken branches do not write.
//  Mispredict: in the same cycle fetch_pc<=actual_next and all slots invalidated.
//   - The update of the mispredicting branch itself is still issued.
//  mispredict_count: +1 per mispredict, saturates at 32'hFFFF_FFFF.
//  Arithmetic: PC adds are 64-bit modulo; wrap at 2^64 is legal, no flag.
//  Mispredict in FLUSH is impossible because slots are invalid; ex_valid is ignored there.
//  arst_n low at any time returns everything to reset values immediately.
//   - The next fetch after release is RESET_PC via BOOT.
// STRUCTURE
//  Shared package: PC_W=64, INSTR_BYTES, FSM state encoding {BOOT,RUN,FLUSH}, tracking-slot struct layout.
//  One sub-module: pred_track_queue (PIPE_DEPTH shift register with push/flush; oldest-slot output).
//  Next-PC mux, compare, FSM and counter stay in the top.
// TESTING
//  1. Reset release, en=1, BTB always 0:
//     fetch_pc = 0, 4, 8, 12; no flush; count 0.
//  2. BTB returns 64'h100 while fetch_pc=8:
//     next fetch_pc=0x100; branch at 8 resolves taken to 0x100 -> no flush, btb_was_taken=1 with prev=8, target=0x100.
//  3. Not-predicted branch at 0x10 resolves taken to 0x200:
//     next cycle flush=1, fetch_valid=0; then fetch_pc=0x200, 0x204; count=1.
//  4. Predicted 0x300 at 0x20 but resolves not-taken:
//     redirect to 0x24, flush pulse, count=2, btb_was_taken=0.
//  5. Stall en=0 for 3 cycles with a mispredict in the 2nd:
//     redirect applied despite stall; fetch_pc holds otherwise.
//  6. arst_n low mid-FLUSH:
//     flush drops at once, slots cleared; after release fetch_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_predictor_pkg.sv
// Shared types for the fetch next-PC predictor: PC width, FSM encoding,
// tracking-slot layout and the saturating counter helper.
package fetch_pc_predictor_pkg;

  localparam int PC_W            = 64;
  localparam int DEF_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred_next;
  } track_slot_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pred_track_queue.sv
// Shift register holding {valid, pc, predicted next-PC} for every instruction
// between fetch and EX; the oldest entry is the one EX is resolving.
module pred_track_queue
  import fetch_pc_predictor_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        push,
  input  logic        clear,
  input  track_slot_t push_slot,
  output track_slot_t oldest
);

  logic [DEPTH-1:0] r_valid;
  logic [PC_W-1:0]  r_pc   [DEPTH];
  logic [PC_W-1:0]  r_pred [DEPTH];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid <= '0;
    end else if (clear) begin
      r_valid <= '0;
    end else if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) r_valid[i] <= r_valid[i-1];
      r_valid[0] <= push_slot.valid;
    end
  end

  // Payload is only meaningful under its valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_pc[i]   <= r_pc[i-1];
        r_pred[i] <= r_pred[i-1];
      end
      r_pc[0]   <= push_slot.pc;
      r_pred[0] <= push_slot.pred_next;
    end
  end

  assign oldest.valid     = r_valid[DEPTH-1];
  assign oldest.pc        = r_pc[DEPTH-1];
  assign oldest.pred_next = r_pred[DEPTH-1];

endmodule

// File: rtl/fetch_pc_predictor.sv
// Fetch-stage next-PC generator around the BTB: picks the next fetch address,
// tracks predictions until EX resolves them, redirects on mispredict, feeds BTB updates.
module fetch_pc_predictor
  import fetch_pc_predictor_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              PIPE_DEPTH  = 2,
  parameter int              INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            en,
  input  logic [PC_W-1:0] predicted_branch_pc,
  output logic [PC_W-1:0] current_pc,
  output logic [PC_W-1:0] fetch_pc,
  output logic            fetch_valid,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  output logic            flush,
  output logic [PC_W-1:0] btb_prev_pc,
  output logic [PC_W-1:0] btb_branch_pc,
  output logic            btb_was_taken,
  output logic [31:0]     mispredict_count
);

  localparam logic [PC_W-1:0] LP_INC = PC_W'(INSTR_BYTES);

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic            r_fetch_valid;
  logic            r_flush;
  logic [PC_W-1:0] r_btb_prev;
  logic [PC_W-1:0] r_btb_tgt;
  logic            r_btb_taken;
  logic [31:0]     r_mis_cnt;

  track_slot_t     w_oldest;
  track_slot_t     w_push_slot;
  logic            w_run;
  logic            w_resolved;
  logic            w_mispredict;
  logic            w_push;
  logic [PC_W-1:0] w_actual_next;
  logic [PC_W-1:0] w_next_pc;

  assign w_run         = (r_state == ST_RUN);
  // Outside RUN every slot is invalid, so ex_valid cannot resolve anything there.
  assign w_resolved    = w_run & ex_valid & w_oldest.valid;
  assign w_actual_next = (ex_is_branch & ex_taken) ? ex_target : w_oldest.pc + LP_INC;
  assign w_mispredict  = w_resolved & (w_actual_next != w_oldest.pred_next);

  always_comb begin
    w_next_pc = r_fetch_pc;
    case (r_state)
      ST_BOOT: w_next_pc = RESET_PC;
      ST_RUN: begin
        if (w_mispredict)                  w_next_pc = w_actual_next;
        else if (!en)                      w_next_pc = r_fetch_pc;
        else if (predicted_branch_pc != '0) w_next_pc = predicted_branch_pc;
        else                               w_next_pc = r_fetch_pc + LP_INC;
      end
      default: w_next_pc = r_fetch_pc;
    endcase
  end

  assign w_push                = w_run & en & ~w_mispredict;
  assign w_push_slot.valid     = r_fetch_valid;
  assign w_push_slot.pc        = r_fetch_pc;
  assign w_push_slot.pred_next = w_next_pc;

  pred_track_queue #(
    .DEPTH (PIPE_DEPTH)
  ) u_track (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (w_push),
    .clear     (w_mispredict),
    .push_slot (w_push_slot),
    .oldest    (w_oldest)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_btb_prev    <= '0;
      r_btb_tgt     <= '0;
      r_btb_taken   <= 1'b0;
      r_mis_cnt     <= '0;
    end else begin
      r_flush     <= 1'b0;
      r_btb_taken <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_fetch_pc    <= RESET_PC;
          r_fetch_valid <= 1'b1;
          r_state       <= ST_RUN;
        end
        ST_RUN: begin
          r_fetch_pc  <= w_next_pc;
          r_btb_taken <= w_resolved & ex_is_branch & ex_taken;
          if (w_resolved & ex_is_branch) begin
            r_btb_prev <= w_oldest.pc;
            r_btb_tgt  <= ex_target;
          end
          // The redirect target is already in fetch_pc when FLUSH is visible.
          if (w_mispredict) begin
            r_state       <= ST_FLUSH;
            r_flush       <= 1'b1;
            r_fetch_valid <= 1'b0;
            r_mis_cnt     <= sat_inc32(r_mis_cnt);
          end
        end
        ST_FLUSH: begin
          r_fetch_valid <= 1'b1;
          r_state       <= ST_RUN;
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign current_pc       = w_next_pc;
  assign fetch_pc         = r_fetch_pc;
  assign fetch_valid      = r_fetch_valid;
  assign flush            = r_flush;
  assign btb_prev_pc      = r_btb_prev;
  assign btb_branch_pc    = r_btb_tgt;
  assign btb_was_taken    = r_btb_taken;
  assign mispredict_count = r_mis_cnt;

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Bench for fetch_pc_predictor: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against an in-bench model.
module tb_fetch_pc_predictor;

  localparam logic [63:0] RESET_PC   = 64'h0;
  localparam int          PIPE_DEPTH = 2;
  localparam logic [63:0] IB         = 64'd4;

  logic        clk;
  logic        arst_n;
  logic        en;
  logic [63:0] predicted_branch_pc;
  logic [63:0] current_pc;
  logic [63:0] fetch_pc;
  logic        fetch_valid;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        flush;
  logic [63:0] btb_prev_pc;
  logic [63:0] btb_branch_pc;
  logic        btb_was_taken;
  logic [31:0] mispredict_count;

  fetch_pc_predictor #(
    .RESET_PC    (RESET_PC),
    .PIPE_DEPTH  (PIPE_DEPTH),
    .INSTR_BYTES (4)
  ) dut (
    .clk                 (clk),
    .arst_n              (arst_n),
    .en                  (en),
    .predicted_branch_pc (predicted_branch_pc),
    .current_pc          (current_pc),
    .fetch_pc            (fetch_pc),
    .fetch_valid         (fetch_valid),
    .ex_valid            (ex_valid),
    .ex_is_branch        (ex_is_branch),
    .ex_taken            (ex_taken),
    .ex_target           (ex_target),
    .flush               (flush),
    .btb_prev_pc         (btb_prev_pc),
    .btb_branch_pc       (btb_branch_pc),
    .btb_was_taken       (btb_was_taken),
    .mispredict_count    (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: in-flight instructions, youngest at the front, EX reads the back.
  typedef struct {
    bit          v;
    logic [63:0] pc;
    logic [63:0] pred;
  } rec_t;

  rec_t        trk[$];
  bit          m_boot, m_flush, m_fv, m_btbv;
  logic [63:0] m_pc, m_prev, m_tgt;
  logic [31:0] m_cnt;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    rec_t e;
    m_boot = 1; m_flush = 0; m_fv = 0; m_btbv = 0;
    m_pc = RESET_PC; m_prev = '0; m_tgt = '0; m_cnt = '0;
    e.v = 0; e.pc = '0; e.pred = '0;
    trk.delete();
    for (int i = 0; i < PIPE_DEPTH; i++) trk.push_back(e);
  endtask

  // One clock: drive inputs at negedge, compare, advance the model, step past posedge.
  task automatic cyc(input bit e, input logic [63:0] bp, input bit xv, input bit xb,
                     input bit xt, input logic [63:0] xg);
    rec_t        o;
    rec_t        n;
    bit          res, mis;
    logic [63:0] act, cur;
    @(negedge clk);
    en = e; predicted_branch_pc = bp;
    ex_valid = xv; ex_is_branch = xb; ex_taken = xt; ex_target = xg;
    #1;
    o = trk[$];
    res = 0; mis = 0; act = '0;
    if (m_boot) cur = RESET_PC;
    else if (m_flush) cur = m_pc;
    else begin
      res = xv && o.v;
      act = (xb && xt) ? xg : o.pc + IB;
      mis = res && (act != o.pred);
      if (mis) cur = act;
      else if (!e) cur = m_pc;
      else if (bp != 0) cur = bp;
      else cur = m_pc + IB;
    end
    chk("current_pc", current_pc, cur);
    chk("fetch_pc", fetch_pc, m_pc);
    chk("fetch_valid", 64'(fetch_valid), 64'(m_fv));
    chk("flush", 64'(flush), 64'(m_flush));
    chk("btb_was_taken", 64'(btb_was_taken), 64'(m_btbv));
    chk("mispredict_count", 64'(mispredict_count), 64'(m_cnt));
    if (m_btbv) begin
      chk("btb_prev_pc", btb_prev_pc, m_prev);
      chk("btb_branch_pc", btb_branch_pc, m_tgt);
    end
    if (m_boot) begin
      m_boot = 0; m_fv = 1; m_btbv = 0;
    end else if (m_flush) begin
      m_flush = 0; m_fv = 1; m_btbv = 0;
    end else begin
      m_btbv = res && xb && xt;
      if (res && xb) begin m_prev = o.pc; m_tgt = xg; end
      if (mis) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_pc = act; m_fv = 0; m_flush = 1;
        foreach (trk[i]) trk[i].v = 0;
      end else if (e) begin
        n.v = m_fv; n.pc = m_pc; n.pred = cur;
        trk.push_front(n);
        void'(trk.pop_back());
        m_pc = cur;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pick_pc(input logic [63:0] base);
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
    if (r < 3) return base + IB;
    return 64'($urandom_range(0, 1023)) << 2;
  endfunction

  task automatic rand_cyc();
    rec_t        o;
    bit          e, xv, xb, xt;
    logic [63:0] bp, xg;
    int unsigned r;
    o = trk[$];
    e = ($urandom_range(0, 9) < 8);
    r = $urandom_range(0, 9);
    if (r < 6) bp = '0;
    else if (r < 9) bp = 64'($urandom_range(1, 1023)) << 2;
    else bp = 64'hFFFF_FFFF_FFFF_FFFC;
    xv = o.v ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
    xb = $urandom_range(0, 1) == 1;
    if ($urandom_range(0, 1) == 1) begin
      xt = (o.pred != o.pc + IB);
      xg = o.pred;
    end else begin
      xt = $urandom_range(0, 1) == 1;
      xg = pick_pc(o.pc);
    end
    cyc(e, bp, xv, xb, xt, xg);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_pc", fetch_pc, RESET_PC);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_btb_taken", 64'(btb_was_taken), 64'd0);
    chk("rst_btb_prev", btb_prev_pc, 64'd0);
    chk("rst_btb_tgt", btb_branch_pc, 64'd0);
    chk("rst_count", 64'(mispredict_count), 64'd0);
    chk("rst_current_pc", current_pc, RESET_PC);
    arst_n = 1'b1;
  endtask

  initial begin
    en = 0; predicted_branch_pc = '0; ex_valid = 0; ex_is_branch = 0;
    ex_taken = 0; ex_target = '0; arst_n = 1'b1;
    #2;
    do_reset();

    // Sequential fetch from reset, then an unpredicted taken branch at 0x10.
    cyc(1, 0, 0, 0, 0, 0); chk("t1_pc0", fetch_pc, 64'h0); chk("t1_fv", 64'(fetch_valid), 64'd1);
    cyc(1, 0, 0, 0, 0, 0); chk("t1_pc4", fetch_pc, 64'h4);
    cyc(1, 0, 0, 0, 0, 0); chk("t1_pc8", fetch_pc, 64'h8);
    cyc(1, 0, 1, 0, 0, 0); chk("t1_pc12", fetch_pc, 64'hC);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0); chk("t1_noflush", 64'(flush), 64'd0);
    chk("t1_count", 64'(mispredict_count), 64'd0);
    cyc(1, 0, 1, 1, 1, 64'h200);
    chk("t3_flush", 64'(flush), 64'd1); chk("t3_fv", 64'(fetch_valid), 64'd0);
    chk("t3_pc", fetch_pc, 64'h200); chk("t3_count", 64'(mispredict_count), 64'd1);
    chk("t3_btb", 64'(btb_was_taken), 64'd1); chk("t3_prev", btb_prev_pc, 64'h10);
    chk("t3_tgt", btb_branch_pc, 64'h200);
    cyc(1, 0, 1, 1, 1, 64'h600);
    chk("t3_flush_end", 64'(flush), 64'd0); chk("t3_pc_hold", fetch_pc, 64'h200);
    chk("t3_fv_back", 64'(fetch_valid), 64'd1);
    cyc(1, 0, 1, 1, 1, 64'h700);
    chk("t3_pc204", fetch_pc, 64'h204); chk("t3_ignored", 64'(mispredict_count), 64'd1);

    // BTB-predicted taken branch that resolves as predicted.
    cyc(1, 64'h100, 0, 0, 0, 0); chk("t2_pc", fetch_pc, 64'h100);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 64'h100);
    chk("t2_btb", 64'(btb_was_taken), 64'd1); chk("t2_prev", btb_prev_pc, 64'h204);
    chk("t2_tgt", btb_branch_pc, 64'h100); chk("t2_noflush", 64'(flush), 64'd0);
    chk("t2_pc_next", fetch_pc, 64'h108);

    // Predicted-taken branch that resolves not-taken.
    cyc(1, 64'h300, 1, 0, 0, 0); chk("t4_pc", fetch_pc, 64'h300);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 64'h300);
    chk("t4_pc_redirect", fetch_pc, 64'h10C); chk("t4_flush", 64'(flush), 64'd1);
    chk("t4_count", 64'(mispredict_count), 64'd2); chk("t4_btb", 64'(btb_was_taken), 64'd0);
    cyc(1, 0, 0, 0, 0, 0);

    // Three-cycle stall with the redirect landing in the second cycle.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0); chk("t5_pc_pre", fetch_pc, 64'h114);
    cyc(0, 64'h900, 0, 0, 0, 0); chk("t5_hold", fetch_pc, 64'h114);
    cyc(0, 0, 1, 1, 1, 64'h400);
    chk("t5_redirect", fetch_pc, 64'h400); chk("t5_count", 64'(mispredict_count), 64'd3);
    cyc(0, 0, 0, 0, 0, 0); chk("t5_fv", 64'(fetch_valid), 64'd1);
    cyc(1, 0, 0, 0, 0, 0); chk("t5_pc404", fetch_pc, 64'h404);

    // Asynchronous reset asserted in the middle of a FLUSH cycle.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 64'h500); chk("t6_in_flush", 64'(flush), 64'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t6_flush_drop", 64'(flush), 64'd0);
    chk("t6_pc", fetch_pc, RESET_PC);
    chk("t6_count", 64'(mispredict_count), 64'd0);
    @(posedge clk);
    #1;
    do_reset();
    cyc(1, 0, 1, 1, 1, 64'h800); chk("t6_boot_pc", fetch_pc, RESET_PC);
    chk("t6_boot_fv", 64'(fetch_valid), 64'd1);

    repeat (4000) rand_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
